risk_limit_ram: RTL and testbench
=================================

RISK_LIMIT_RAM -- requirements
Module: risk_limit_ram

Interface
REQ-001 SHALL have parameter D_WIDTH, default 32, data width of each stored field.
REQ-002 SHALL have parameter A_WIDTH, default 5, address width.
REQ-003 SHALL have parameter A_MAX, default 32, number of implemented entries (A_MAX <= 2^A_WIDTH).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  1  request present this cycle.
REQ-007 SHALL have port req_ready  output  1  request accepted when req_valid && req_ready.
REQ-008 SHALL have port req_op  input  2  00 ACCUM, 01 SET_MAX, 10 CLEAR, 11 READ.
REQ-009 SHALL have port req_addr  input  A_WIDTH  entry index.
REQ-010 SHALL have port req_data  input  D_WIDTH  order quantity (ACCUM) or new limit (SET_MAX).
REQ-011 SHALL have port rsp_valid  output  1  one-cycle pulse per accepted request; no backpressure.
REQ-012 SHALL have port rsp_addr  output  A_WIDTH  address of the responding request.
REQ-013 SHALL have port rsp_accum  output  D_WIDTH  accumulated_orders after the operation.
REQ-014 SHALL have port rsp_max  output  D_WIDTH  max_to_trade after the operation.
REQ-015 SHALL have port rsp_reject  output  1  operation refused; entry unchanged.

Function
REQ-016 SHALL store per entry two D_WIDTH fields: accum (accumulated_orders) and max (max_to_trade).
REQ-017 SHALL implement states INIT and RUN; INIT sweeps a counter 0..A_MAX-1 writing accum=0, max=0 one entry per cycle, then enters RUN.
REQ-018 SHALL drive req_ready=0 in INIT and req_ready=1 in RUN.
REQ-019 SHALL process requests in a 2-stage pipeline (S1 read, S2 compute/write), one request per cycle, rsp_valid exactly 2 cycles after the accepting edge.
REQ-020 ACCUM SHALL compute sum=accum+req_data in D_WIDTH+1 bits; if sum > max or sum[D_WIDTH]=1, reject, else write accum=sum[D_WIDTH-1:0].
REQ-021 SET_MAX SHALL write max=req_data, never reject, and leave accum unchanged even if accum > new max.
REQ-022 CLEAR SHALL write accum=0, max unchanged; READ SHALL write nothing and report current fields.
REQ-023 SHALL, for req_addr >= A_MAX, assert rsp_reject, write nothing, and return rsp_accum=0, rsp_max=0.
REQ-024 SHALL forward the S2 write result into S1 when consecutive requests hit the same address, so back-to-back ACCUMs to one entry see each other's result with zero bubbles.
REQ-025 rsp_accum/rsp_max SHALL reflect the post-operation values (pre-operation values on reject).
REQ-026 SHALL hold rsp_addr, rsp_accum, rsp_max, rsp_reject at their last values when rsp_valid=0.

Reset
REQ-027 On rst=1 SHALL set state=INIT, sweep counter=0, req_ready=0, rsp_valid=0, rsp_reject=0, rsp_addr=0, rsp_accum=0, rsp_max=0.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight requests with no response pulse and re-run the full INIT sweep.
REQ-029 After rst deasserts, req_ready SHALL rise exactly A_MAX cycles later.

Configuration
REQ-030 With RISK_LIMIT_RAM_STATS_EN defined SHALL add output reject_count (16 bits, reset 0, +1 per rsp_reject pulse, saturating at 0xFFFF); without it the port and counter SHALL not exist.

Verification
REQ-031 Reset, wait A_MAX=32 cycles -> req_ready=1; READ addr 0x1B -> rsp accum=0, max=0, reject=0, exactly 2 cycles after acceptance.
REQ-032 SET_MAX 0x1B=0x05A3, ACCUM 0x1B +0x08, ACCUM 0x1B +0x03 on consecutive cycles -> accum responses 0x08 then 0x0B, max=0x05A3, no rejects.
REQ-033 max=0x10, accum=0x0B, ACCUM +0x06 -> reject=1, accum stays 0x0B; ACCUM +0x05 -> accum=0x10, reject=0.
REQ-034 max=0xFFFFFFFF, accum=0xFFFFFFF0, ACCUM +0x20 -> reject=1 (carry), entry unchanged; ACCUM at addr 0x1F with A_MAX=16 -> reject=1, zeros returned.
REQ-035 rst pulsed one cycle after an ACCUM is accepted -> no rsp_valid, req_ready low 32 cycles, READ of that entry returns 0/0; with RISK_LIMIT_RAM_STATS_EN, reject_count counts 0x03 after three rejects and 0 after reset.

Source files
------------

// File: rtl/risk_limit_ram.sv
// Per-entry risk limit store (accumulated orders / max to trade) with a 2-stage read-modify-write pipeline.
// Optional reject statistics counter enabled by defining RISK_LIMIT_RAM_STATS_EN.
module risk_limit_ram #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 5,
    parameter int A_MAX   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_op,
    input  logic [A_WIDTH-1:0] req_addr,
    input  logic [D_WIDTH-1:0] req_data,
    output logic               rsp_valid,
    output logic [A_WIDTH-1:0] rsp_addr,
    output logic [D_WIDTH-1:0] rsp_accum,
    output logic [D_WIDTH-1:0] rsp_max,
`ifdef RISK_LIMIT_RAM_STATS_EN
    output logic               rsp_reject,
    output logic [15:0]        reject_count
`else
    output logic               rsp_reject
`endif
);
    localparam logic [1:0] OP_ACCUM   = 2'b00;
    localparam logic [1:0] OP_SET_MAX = 2'b01;
    localparam logic [1:0] OP_CLEAR   = 2'b10;
    localparam logic [1:0] OP_READ    = 2'b11;
    localparam logic [A_WIDTH:0]   AMAX_EXT = (A_WIDTH+1)'(A_MAX);
    localparam logic [A_WIDTH-1:0] CNT_LAST = A_WIDTH'(A_MAX - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t             state, state_nxt;
    logic [A_WIDTH-1:0] init_cnt;
    logic               init_we;

    logic [D_WIDTH-1:0] accum_mem [A_MAX];
    logic [D_WIDTH-1:0] max_mem   [A_MAX];

    logic               vld_p1;
    logic [1:0]         op_p1;
    logic [A_WIDTH-1:0] addr_p1;
    logic [D_WIDTH-1:0] data_p1;
    logic               inr_p1, fwd_p1;
    logic [D_WIDTH-1:0] rd_accum_p1, rd_max_p1;

    logic               vld_p2, inr_p2;
    logic [1:0]         op_p2;
    logic [A_WIDTH-1:0] addr_p2;
    logic signed [D_WIDTH-1:0] data_p2;
    logic [D_WIDTH-1:0] accum_p2, max_p2;
    logic [D_WIDTH-1:0] new_accum_p2, new_max_p2;
    logic               reject_p2, wr_en_p2;

    // Sum in D_WIDTH+1 bits; a carry or exceeding the limit refuses the order.
    function automatic logic accum_exceeds(input logic [D_WIDTH-1:0] acc,
                                           input logic [D_WIDTH-1:0] qty,
                                           input logic [D_WIDTH-1:0] lim,
                                           output logic [D_WIDTH-1:0] sum);
        logic [D_WIDTH:0] s;
        s   = {1'b0, acc} + {1'b0, qty};
        sum = s[D_WIDTH-1:0];
        return s[D_WIDTH] || (s > {1'b0, lim});
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= ST_INIT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == ST_INIT && init_cnt == CNT_LAST) state_nxt = ST_RUN;
    end

    always_comb begin
        req_ready = (state == ST_RUN);
        init_we   = (state == ST_INIT);
    end

    always_ff @(posedge clk) begin
        if (rst)          init_cnt <= '0;
        else if (init_we) init_cnt <= init_cnt + A_WIDTH'(1);
    end

    // Stage 0 -> 1: capture accepted request
    always_ff @(posedge clk) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= req_valid && req_ready;
    end

    always_ff @(posedge clk) begin
        op_p1   <= req_op;
        addr_p1 <= req_addr;
        data_p1 <= req_data;
    end

    // Stage 1: read entry, bypassing the stage-2 write to the same address
    always_comb begin
        inr_p1      = ({1'b0, addr_p1} < AMAX_EXT);
        fwd_p1      = wr_en_p2 && (addr_p2 == addr_p1);
        rd_accum_p1 = '0;
        rd_max_p1   = '0;
        if (fwd_p1) begin
            rd_accum_p1 = new_accum_p2;
            rd_max_p1   = new_max_p2;
        end else if (inr_p1) begin
            rd_accum_p1 = accum_mem[addr_p1];
            rd_max_p1   = max_mem[addr_p1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) vld_p2 <= 1'b0;
        else     vld_p2 <= vld_p1;
    end

    always_ff @(posedge clk) begin
        op_p2    <= op_p1;
        addr_p2  <= addr_p1;
        data_p2  <= data_p1;
        inr_p2   <= inr_p1;
        accum_p2 <= rd_accum_p1;
        max_p2   <= rd_max_p1;
    end

    // Stage 2: compute new entry and decide write/reject
    always_comb begin
        logic [D_WIDTH-1:0] sum;
        sum          = '0;
        new_accum_p2 = accum_p2;
        new_max_p2   = max_p2;
        reject_p2    = 1'b0;
        if (!inr_p2) begin
            reject_p2    = 1'b1;
            new_accum_p2 = '0;
            new_max_p2   = '0;
        end else begin
            case (op_p2)
                OP_ACCUM: begin
                    reject_p2 = accum_exceeds(accum_p2, data_p2, max_p2, sum);
                    if (!reject_p2) new_accum_p2 = sum;
                end
                OP_SET_MAX: new_max_p2   = data_p2;
                OP_CLEAR:   new_accum_p2 = '0;
                default:    ;
            endcase
        end
        wr_en_p2 = vld_p2 && inr_p2 && !reject_p2 && (op_p2 != OP_READ);
    end

    always_ff @(posedge clk) begin
        if (init_we) begin
            accum_mem[init_cnt] <= '0;
            max_mem[init_cnt]   <= '0;
        end else if (wr_en_p2) begin
            accum_mem[addr_p2] <= new_accum_p2;
            max_mem[addr_p2]   <= new_max_p2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_addr   <= '0;
            rsp_accum  <= '0;
            rsp_max    <= '0;
            rsp_reject <= 1'b0;
        end else begin
            rsp_valid <= vld_p2;
            if (vld_p2) begin
                rsp_addr   <= addr_p2;
                rsp_accum  <= new_accum_p2;
                rsp_max    <= new_max_p2;
                rsp_reject <= reject_p2;
            end
        end
    end

`ifdef RISK_LIMIT_RAM_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)                        reject_count <= '0;
        else if (vld_p2 && reject_p2)   reject_count <= sat_inc16(reject_count);
    end
`endif
endmodule

// File: tb/tb_risk_limit_ram.sv
// Randomized bench for risk_limit_ram: two instances (A_MAX=32 and A_MAX=16) against an array/queue model.
// Reject counter is also checked when RISK_LIMIT_RAM_STATS_EN is defined.
module tb_risk_limit_ram;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = 2'b00;
    logic [4:0]  req_addr = '0;
    logic [31:0] req_data = '0;

    logic        ready_a, vld_a, rej_a, ready_b, vld_b, rej_b;
    logic [4:0]  addr_a, addr_b;
    logic [31:0] acc_a, max_a, acc_b, max_b;
    logic [15:0] rc_a, rc_b;

    always #5 clk = ~clk;

    risk_limit_ram #(.D_WIDTH(32), .A_WIDTH(5), .A_MAX(32)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_a),
        .req_op(req_op), .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(vld_a), .rsp_addr(addr_a), .rsp_accum(acc_a), .rsp_max(max_a),
`ifdef RISK_LIMIT_RAM_STATS_EN
        .rsp_reject(rej_a), .reject_count(rc_a)
`else
        .rsp_reject(rej_a)
`endif
    );

    risk_limit_ram #(.D_WIDTH(32), .A_WIDTH(5), .A_MAX(16)) u_dut16 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_b),
        .req_op(req_op), .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(vld_b), .rsp_addr(addr_b), .rsp_accum(acc_b), .rsp_max(max_b),
`ifdef RISK_LIMIT_RAM_STATS_EN
        .rsp_reject(rej_b), .reject_count(rc_b)
`else
        .rsp_reject(rej_b)
`endif
    );

`ifndef RISK_LIMIT_RAM_STATS_EN
    assign rc_a = '0;
    assign rc_b = '0;
`endif

    typedef struct {
        int          cyc;
        logic [4:0]  addr;
        logic [31:0] acc;
        logic [31:0] mx;
        logic        rej;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] m_acc [2][32];
    logic [31:0] m_max [2][32];
    logic [31:0] last_acc [2];
    logic [15:0] m_rc [2];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    bit          in_reset = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int i = 0; i < 2; i++) begin
            last_acc[i] = '0;
            m_rc[i]     = '0;
            for (int j = 0; j < 32; j++) begin
                m_acc[i][j] = '0;
                m_max[i][j] = '0;
            end
        end
    endtask

    // Sequential semantics: each accepted request sees all earlier ones, in order.
    task automatic issue(input int i, input logic [1:0] op, input logic [4:0] a,
                         input logic [31:0] d, input int due);
        exp_t        e;
        logic [32:0] s;
        int          amax;
        amax  = (i == 0) ? 32 : 16;
        e.cyc = due;
        e.addr = a;
        e.rej = 1'b0;
        if (int'(a) >= amax) begin
            e.rej = 1'b1;
            e.acc = '0;
            e.mx  = '0;
        end else begin
            case (op)
                2'b00: begin
                    s = {1'b0, m_acc[i][a]} + {1'b0, d};
                    if (s > {1'b0, m_max[i][a]}) e.rej = 1'b1;
                    else m_acc[i][a] = s[31:0];
                end
                2'b01: m_max[i][a] = d;
                2'b10: m_acc[i][a] = '0;
                default: ;
            endcase
            e.acc = m_acc[i][a];
            e.mx  = m_max[i][a];
        end
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic mon(input int i, input logic v, input logic [4:0] a, input logic [31:0] acc,
                       input logic [31:0] mx, input logic rej, input logic [15:0] rc);
        exp_t e;
        bit   have;
        string sfx;
        sfx  = (i == 0) ? "_a" : "_b";
        have = 1'b0;
        if (i == 0 && q0.size() > 0 && q0[0].cyc == cyc) begin e = q0.pop_front(); have = 1'b1; end
        if (i == 1 && q1.size() > 0 && q1[0].cyc == cyc) begin e = q1.pop_front(); have = 1'b1; end
        if (have) begin
            check({"rsp_valid", sfx}, 64'(v), 64'd1);
            check({"rsp_addr", sfx}, 64'(a), 64'(e.addr));
            check({"rsp_accum", sfx}, 64'(acc), 64'(e.acc));
            check({"rsp_max", sfx}, 64'(mx), 64'(e.mx));
            check({"rsp_reject", sfx}, 64'(rej), 64'(e.rej));
            last_acc[i] = e.acc;
            if (e.rej && m_rc[i] != 16'hFFFF) m_rc[i] = m_rc[i] + 16'd1;
`ifdef RISK_LIMIT_RAM_STATS_EN
            check({"reject_count", sfx}, 64'(rc), 64'(m_rc[i]));
`endif
        end else begin
            check({"idle_valid", sfx}, 64'(v), 64'd0);
            check({"hold_accum", sfx}, 64'(acc), 64'(last_acc[i]));
        end
    endtask

    always @(negedge clk) begin
        if (!in_reset) begin
            mon(0, vld_a, addr_a, acc_a, max_a, rej_a, rc_a);
            mon(1, vld_b, addr_b, acc_b, max_b, rej_b, rc_b);
        end
    end

    task automatic send(input logic [1:0] op, input logic [4:0] a, input logic [31:0] d);
        check("ready_at_send", 64'(ready_a && ready_b), 64'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_data  = d;
        issue(0, op, a, d, cyc + 3);
        issue(1, op, a, d, cyc + 3);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        check("rst_ready_a", 64'(ready_a), 64'd0);
        check("rst_valid_a", 64'(vld_a), 64'd0);
        check("rst_addr_a", 64'(addr_a), 64'd0);
        check("rst_accum_a", 64'(acc_a), 64'd0);
        check("rst_max_a", 64'(max_a), 64'd0);
        check("rst_reject_a", 64'(rej_a), 64'd0);
        check("rst_valid_b", 64'(vld_b), 64'd0);
`ifdef RISK_LIMIT_RAM_STATS_EN
        check("rst_reject_count_a", 64'(rc_a), 64'd0);
`endif
    endtask

    task automatic wait_ready();
        int n, na, nb;
        n = 0; na = -1; nb = -1;
        while (n < 100 && (na < 0 || nb < 0)) begin
            @(negedge clk);
            n++;
            if (na < 0 && ready_a) na = n;
            if (nb < 0 && ready_b) nb = n;
        end
        check("ready_latency_a", 64'(na), 64'd32);
        check("ready_latency_b", 64'(nb), 64'd16);
    endtask

    task automatic do_reset();
        req_valid = 1'b0;
        rst       = 1'b1;
        in_reset  = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs();
        in_reset = 1'b0;
        wait_ready();
    endtask

    task automatic random_phase(input int n);
        logic [4:0]  a;
        logic [1:0]  op;
        logic [31:0] d;
        logic [4:0]  hot [4];
        hot[0] = 5'h1B; hot[1] = 5'h1F; hot[2] = 5'h03; hot[3] = 5'h0F;
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle(1);
            end else begin
                a  = ($urandom_range(0, 2) != 0) ? hot[$urandom_range(0, 3)] : 5'($urandom_range(0, 31));
                op = 2'($urandom_range(0, 3));
                case ($urandom_range(0, 5))
                    0:       d = $urandom;
                    1:       d = 32'hFFFF_FFFF - 32'($urandom_range(0, 40));
                    default: d = 32'($urandom_range(0, 120));
                endcase
                send(op, a, d);
            end
        end
        idle(5);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        in_reset = 1'b0;
        wait_ready();

        send(2'b11, 5'h1B, 32'h0);
        idle(3);
        send(2'b01, 5'h1B, 32'h0000_05A3);
        send(2'b00, 5'h1B, 32'h08);
        send(2'b00, 5'h1B, 32'h03);
        idle(3);
        send(2'b01, 5'h03, 32'h10);
        send(2'b00, 5'h03, 32'h0B);
        send(2'b00, 5'h03, 32'h06);
        send(2'b00, 5'h03, 32'h05);
        send(2'b01, 5'h03, 32'h01);
        send(2'b11, 5'h03, 32'h0);
        idle(2);
        send(2'b01, 5'h05, 32'hFFFF_FFFF);
        send(2'b00, 5'h05, 32'hFFFF_FFF0);
        send(2'b00, 5'h05, 32'h20);
        send(2'b11, 5'h05, 32'h0);
        send(2'b00, 5'h1F, 32'h01);
        send(2'b10, 5'h03, 32'h0);
        send(2'b11, 5'h03, 32'h0);
        idle(4);

        random_phase(500);

        send(2'b00, 5'h1B, 32'h07);
        do_reset();
        send(2'b11, 5'h1B, 32'h0);
        idle(4);
        random_phase(200);

        check("drain_a", 64'(q0.size()), 64'd0);
        check("drain_b", 64'(q1.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
